filter_port_fifo: RTL

- Filter-side endpoint of the shared-data-bus transfer protocol; one instance per filter (FFT, FIR, IIR).
- Answers the bus controller's put/get requests and drives the full/empty flags the controller qualifies them with.
- Two independent synchronous FIFOs:
  - ingress: bus put -> filter core read.
  - egress: filter core write -> bus get.
- Sticky error flags record protocol violations (put when full, get when empty).

---
 rtl/filter_bus_pkg.sv | 20 ++
 rtl/filter_port_sync_fifo.sv | 82 ++++++++
 rtl/filter_port_fifo.sv | 104 ++++++++++
 3 files changed

// File: rtl/filter_bus_pkg.sv
// +------------------------------------------------------------------+
// | filter_bus_pkg: defaults and filter IDs shared by the bus        |
// | controller and the filter ports.                    Rev 1.0      |
// +------------------------------------------------------------------+
`default_nettype none

package filter_bus_pkg;

  localparam int DATA_W_DEF     = 32;
  localparam int FIFO_DEPTH_DEF = 8;

  typedef enum logic [1:0] {
    FILTER_FFT = 2'd0,
    FILTER_FIR = 2'd1,
    FILTER_IIR = 2'd2
  } filter_id_e;

endpackage

`default_nettype wire

// File: rtl/filter_port_sync_fifo.sv
// +------------------------------------------------------------------+
// | filter_port_sync_fifo: single-clock FIFO with registered pop     |
// | data, registered full/empty/level and reject strobes. Rev 1.0    |
// +------------------------------------------------------------------+
`default_nettype none

module filter_port_sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     push_rej,
  output logic                     pop_rej
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   c_full_lvl = (AW+1)'(DEPTH);
  localparam logic [AW:0]   c_lvl_one  = (AW+1)'(1);
  localparam logic [AW-1:0] c_ptr_one  = AW'(1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       w_level_nxt;
  logic              w_push_ok;
  logic              w_pop_ok;

  // Accept decisions use only pre-edge registered flags.
  assign w_push_ok = push & ~full;
  assign w_pop_ok  = pop & ~empty;
  assign push_rej  = push & full;
  assign pop_rej   = pop & empty;

  always_comb begin
    w_level_nxt = level;
    if (w_push_ok && !w_pop_ok) begin
      w_level_nxt = level + c_lvl_one;
    end else if (w_pop_ok && !w_push_ok) begin
      w_level_nxt = level - c_lvl_one;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      level    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      pop_data <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
        pop_data <= r_mem[r_rd_ptr];
      end
      level <= w_level_nxt;
      full  <= (w_level_nxt == c_full_lvl);
      empty <= (w_level_nxt == '0);
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/filter_port_fifo.sv
// +------------------------------------------------------------------+
// | filter_port_fifo: filter-side bus endpoint, ingress/egress FIFOs |
// | with sticky overflow/underflow flags.               Rev 1.0      |
// +------------------------------------------------------------------+
`default_nettype none

module filter_port_fifo
  import filter_bus_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = FIFO_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     bus_put_req,
  input  logic [DATA_W-1:0]        bus_put_data,
  output logic                     bus_full,
  input  logic                     bus_get_req,
  output logic [DATA_W-1:0]        bus_get_data,
  output logic                     bus_empty,
  input  logic                     core_rd_req,
  output logic [DATA_W-1:0]        core_rd_data,
  output logic                     core_rd_valid,
  input  logic                     core_wr_req,
  input  logic [DATA_W-1:0]        core_wr_data,
  output logic                     core_wr_ready,
  output logic [$clog2(DEPTH):0]   in_level,
  output logic [$clog2(DEPTH):0]   out_level,
  output logic                     ovf_err,
  output logic                     udf_err,
  input  logic                     clear_err
);

  logic w_in_empty;
  logic w_in_push_rej;
  logic w_in_pop_rej;
  logic w_eg_full;
  logic w_eg_push_rej;
  logic w_eg_pop_rej;
  logic w_ovf_set;
  logic w_udf_set;

  filter_port_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ingress (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (bus_put_req),
    .push_data (bus_put_data),
    .pop       (core_rd_req),
    .pop_data  (core_rd_data),
    .full      (bus_full),
    .empty     (w_in_empty),
    .level     (in_level),
    .push_rej  (w_in_push_rej),
    .pop_rej   (w_in_pop_rej)
  );

  filter_port_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_egress (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (core_wr_req),
    .push_data (core_wr_data),
    .pop       (bus_get_req),
    .pop_data  (bus_get_data),
    .full      (w_eg_full),
    .empty     (bus_empty),
    .level     (out_level),
    .push_rej  (w_eg_push_rej),
    .pop_rej   (w_eg_pop_rej)
  );

  assign core_wr_ready = ~w_eg_full;
  assign w_ovf_set     = w_in_push_rej | w_eg_push_rej;
  assign w_udf_set     = w_in_pop_rej  | w_eg_pop_rej;

  // A new violation in the same cycle as clear_err must stay visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_err       <= 1'b0;
      udf_err       <= 1'b0;
      core_rd_valid <= 1'b0;
    end else begin
      if (w_ovf_set) begin
        ovf_err <= 1'b1;
      end else if (clear_err) begin
        ovf_err <= 1'b0;
      end
      if (w_udf_set) begin
        udf_err <= 1'b1;
      end else if (clear_err) begin
        udf_err <= 1'b0;
      end
      core_rd_valid <= core_rd_req & ~w_in_empty;
    end
  end

endmodule

`default_nettype wire
